// File: rtl/sequenciador_exibicao_pkg.sv
// Shared state codes for the LED sequence player; the codes double as the db_estado debug value.
// Also holds the timer-width helper so every user sizes the timer the same way.
package sequenciador_exibicao_pkg;

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    CARREGA = 3'd1,
    ACENDE  = 3'd2,
    APAGA   = 3'd3,
    AVANCA  = 3'd4,
    CONCLUI = 3'd5
  } estado_t;

  // Enough bits to hold the larger of the two terminal values (at least one bit).
  function automatic int tmr_largura(input int on_ciclos, input int off_ciclos);
    int maior;
    maior = (on_ciclos > off_ciclos) ? on_ciclos : off_ciclos;
    return (maior <= 1) ? 1 : $clog2(maior);
  endfunction

endpackage

// File: rtl/sequenciador_exibicao_contador_tempo.sv
// Up-counter with synchronous clear and enable; flags when the count equals terminal_i.
// The flag is combinational from the registered count, so it is valid in the same cycle.
module contador_tempo #(
  parameter int LARGURA = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               limpar_i,
  input  logic               habilitar_i,
  input  logic [LARGURA-1:0] terminal_i,
  output logic               no_terminal_o
);

  logic [LARGURA-1:0] valor_q, valor_d;

  always_comb begin
    valor_d = valor_q;
    if (limpar_i) begin
      valor_d = '0;
    end else if (habilitar_i) begin
      valor_d = valor_q + LARGURA'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      valor_q <= '0;
    end else begin
      valor_q <= valor_d;
    end
  end

  assign no_terminal_o = (valor_q == terminal_i);

endmodule

// File: rtl/sequenciador_exibicao.sv
// Plays stored LED patterns: load, light ON_CICLOS, blank OFF_CICLOS, advance; pulses fim at the end.
// Moore outputs; iniciar is ignored while busy and abortar returns to OCIOSO on the next edge.
module sequenciador_exibicao
  import sequenciador_exibicao_pkg::*;
#(
  parameter int ADDR_W     = 4,
  parameter int DADO_W     = 4,
  parameter int ON_CICLOS  = 500,
  parameter int OFF_CICLOS = 250
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              abortar,
  input  logic [ADDR_W-1:0] ultimo_endereco,
  input  logic [DADO_W-1:0] dado_memoria,
  output logic [ADDR_W-1:0] endereco,
  output logic [DADO_W-1:0] leds,
  output logic              ocupado,
  output logic              fim,
  output logic [2:0]        db_estado
);

  localparam int TMR_W = tmr_largura(ON_CICLOS, OFF_CICLOS);
  localparam logic [TMR_W-1:0] ON_TERM  = TMR_W'(ON_CICLOS - 1);
  localparam logic [TMR_W-1:0] OFF_TERM = TMR_W'(OFF_CICLOS - 1);

  estado_t           estado_q, estado_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] ultimo_q, ultimo_d;
  logic [DADO_W-1:0] padrao_q, padrao_d;

  logic              tmr_limpar;
  logic              tmr_habilitar;
  logic [TMR_W-1:0]  tmr_terminal;
  logic              tmr_fim;

  // The timer only runs while a pattern is lit or blanked; any other state holds it at zero.
  assign tmr_habilitar = (estado_q == ACENDE) || (estado_q == APAGA);
  assign tmr_limpar    = abortar || !tmr_habilitar || tmr_fim;
  assign tmr_terminal  = (estado_q == APAGA) ? OFF_TERM : ON_TERM;

  contador_tempo #(
    .LARGURA(TMR_W)
  ) u_timer (
    .clock_i      (clock),
    .reset_i      (reset),
    .limpar_i     (tmr_limpar),
    .habilitar_i  (tmr_habilitar),
    .terminal_i   (tmr_terminal),
    .no_terminal_o(tmr_fim)
  );

  always_comb begin
    estado_d   = estado_q;
    endereco_d = endereco_q;
    ultimo_d   = ultimo_q;
    padrao_d   = padrao_q;
    if (abortar) begin
      estado_d = OCIOSO;
    end else begin
      case (estado_q)
        OCIOSO: begin
          if (iniciar) begin
            ultimo_d   = ultimo_endereco;
            endereco_d = '0;
            estado_d   = CARREGA;
          end
        end
        CARREGA: begin
          padrao_d = dado_memoria;
          estado_d = ACENDE;
        end
        ACENDE: begin
          if (tmr_fim) estado_d = APAGA;
        end
        APAGA: begin
          // Compare before incrementing so the last address never wraps to zero.
          if (tmr_fim) estado_d = (endereco_q == ultimo_q) ? CONCLUI : AVANCA;
        end
        AVANCA: begin
          endereco_d = endereco_q + ADDR_W'(1);
          estado_d   = CARREGA;
        end
        CONCLUI: estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q   <= OCIOSO;
      endereco_q <= '0;
      ultimo_q   <= '0;
      padrao_q   <= '0;
    end else begin
      estado_q   <= estado_d;
      endereco_q <= endereco_d;
      ultimo_q   <= ultimo_d;
      padrao_q   <= padrao_d;
    end
  end

  assign endereco  = endereco_q;
  assign leds      = (estado_q == ACENDE) ? padrao_q : '0;
  assign ocupado   = (estado_q != OCIOSO);
  assign fim       = (estado_q == CONCLUI);
  assign db_estado = estado_q;

endmodule
